// File: rtl/point_validation_scheduler.sv
// Radius-neighbor inlier test scheduler: issues batch distance reads for one query
// point, accumulates in-radius lanes and reports inlier/outlier once the verdict is known.
module point_validation_scheduler #(
    parameter int unsigned N                 = 16,
    parameter int unsigned LANES             = 32,
    parameter int unsigned ADDR_W            = 16,
    parameter int unsigned NEIGHBOR_TRESHOLD = 30,
    parameter int unsigned MAX_OUT           = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pt_valid,
    output logic              pt_ready,
    input  logic [2*N-1:0]    point_cloud_size,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_batch,
    input  logic              hit_valid,
    input  logic [LANES-1:0]  hit_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_inlier,
    output logic              res_outlier,
    output logic [N-1:0]      res_neighbors,
    output logic              proto_err
);

    localparam int unsigned S_W   = 2 * N;
    localparam int unsigned OUT_W = 4;
    localparam int unsigned PC_W  = $clog2(LANES + 1);
    localparam int unsigned SUM_W = N + PC_W;

    localparam logic [N-1:0]     THRESH  = N'(NEIGHBOR_TRESHOLD);
    localparam logic [N-1:0]     CNT_MAX = {N{1'b1}};
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
    localparam logic [S_W-1:0]   LANES_S = S_W'(LANES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [S_W-1:0]      iss_rem_q, iss_rem_d;
    logic [S_W-1:0]      rec_rem_q, rec_rem_d;
    logic [ADDR_W-1:0]   issued_q, issued_d;
    logic [OUT_W-1:0]    outst_q, outst_d;
    logic [N-1:0]        count_q, count_d;
    logic                rd_en_q, rd_en_d;
    logic                pt_ready_q, pt_ready_d;
    logic                res_valid_q, res_valid_d;
    logic                res_inlier_q, res_inlier_d;
    logic                res_outlier_q, res_outlier_d;
    logic [N-1:0]        res_nb_q, res_nb_d;
    logic                proto_q, proto_d;

    logic                hit_acc;
    logic [LANES-1:0]    valid_mask;
    logic [PC_W-1:0]     hit_cnt;
    logic [SUM_W-1:0]    sum_wide;
    logic [N-1:0]        count_sat;

    assign hit_acc = hit_valid && (outst_q != '0);

    // Lanes past the end of the cloud are masked off; rec_rem_q holds lanes still to arrive.
    always_comb begin
        valid_mask = '0;
        hit_cnt    = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            valid_mask[l] = (S_W'(l) < rec_rem_q);
            hit_cnt       = hit_cnt + PC_W'(hit_mask[l] & valid_mask[l]);
        end
        sum_wide  = SUM_W'(count_q) + SUM_W'(hit_cnt);
        count_sat = (sum_wide > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_wide[N-1:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        iss_rem_d = iss_rem_q;
        rec_rem_d = rec_rem_q;
        issued_d  = issued_q;
        count_d   = count_q;
        outst_d   = outst_q + OUT_W'(rd_en_q) - OUT_W'(hit_acc);

        if (rd_en_q) begin
            issued_d  = issued_q + ADDR_W'(1);
            iss_rem_d = (iss_rem_q > LANES_S) ? (iss_rem_q - LANES_S) : '0;
        end
        if (hit_acc) begin
            rec_rem_d = (rec_rem_q > LANES_S) ? (rec_rem_q - LANES_S) : '0;
        end

        case (state_q)
            IDLE: begin
                if (pt_valid) begin
                    iss_rem_d = point_cloud_size;
                    rec_rem_d = point_cloud_size;
                    issued_d  = '0;
                    outst_d   = '0;
                    count_d   = '0;
                    state_d   = (point_cloud_size == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (count_q >= THRESH) begin
                    state_d = DRAIN;
                end else begin
                    if (hit_acc) begin
                        count_d = count_sat;
                    end
                    if (rec_rem_q == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_en_d       = (state_d == ISSUE) && (iss_rem_d != '0) &&
                        (outst_d < OUT_MAX) && (count_d < THRESH);
        pt_ready_d    = (state_d == IDLE);
        res_valid_d   = (state_d == DONE);
        res_inlier_d  = (state_d == DONE) && (count_d >= THRESH);
        res_outlier_d = (state_d == DONE) && (count_d < THRESH);
        res_nb_d      = (state_d == DONE) ? count_d : '0;
        proto_d       = proto_q | (hit_valid && (outst_q == '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            iss_rem_q     <= '0;
            rec_rem_q     <= '0;
            issued_q      <= '0;
            outst_q       <= '0;
            count_q       <= '0;
            rd_en_q       <= 1'b0;
            pt_ready_q    <= 1'b1;
            res_valid_q   <= 1'b0;
            res_inlier_q  <= 1'b0;
            res_outlier_q <= 1'b0;
            res_nb_q      <= '0;
            proto_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            iss_rem_q     <= iss_rem_d;
            rec_rem_q     <= rec_rem_d;
            issued_q      <= issued_d;
            outst_q       <= outst_d;
            count_q       <= count_d;
            rd_en_q       <= rd_en_d;
            pt_ready_q    <= pt_ready_d;
            res_valid_q   <= res_valid_d;
            res_inlier_q  <= res_inlier_d;
            res_outlier_q <= res_outlier_d;
            res_nb_q      <= res_nb_d;
            proto_q       <= proto_d;
        end
    end

    assign pt_ready      = pt_ready_q;
    assign rd_en         = rd_en_q;
    assign rd_batch      = issued_q;
    assign res_valid     = res_valid_q;
    assign res_inlier    = res_inlier_q;
    assign res_outlier   = res_outlier_q;
    assign res_neighbors = res_nb_q;
    assign proto_err     = proto_q;

endmodule

// File: doc/point_validation_scheduler.md
POINT_VALIDATION_SCHEDULER -- requirements
Module: point_validation_scheduler

Interface
REQ-001 SHALL have parameter N, default 16, coordinate/count width.
REQ-002 SHALL have parameter LANES, default 32, distance lanes per batch.
REQ-003 SHALL have parameter ADDR_W, default 16, batch-index width.
REQ-004 SHALL have parameter NEIGHBOR_TRESHOLD, default 30, inlier neighbor count.
REQ-005 SHALL have parameter MAX_OUT, default 4, maximum outstanding batch reads (1..15).
REQ-006 SHALL have port clock  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high.
REQ-008 SHALL have port pt_valid  in  1  new query point available.
REQ-009 SHALL have port pt_ready  out  1  scheduler idle, query accepted on pt_valid&pt_ready.
REQ-010 SHALL have port point_cloud_size  in  2N  cloud point count, sampled at acceptance.
REQ-011 SHALL have port rd_en  out  1  issue one batch read.
REQ-012 SHALL have port rd_batch  out  ADDR_W  batch index of the issued read.
REQ-013 SHALL have port hit_valid  in  1  one in-order batch response.
REQ-014 SHALL have port hit_mask  in  LANES  per-lane distance<radius flags.
REQ-015 SHALL have port res_valid  out  1  result available.
REQ-016 SHALL have port res_ready  in  1  result consumed on res_valid&res_ready.
REQ-017 SHALL have port res_inlier / res_outlier  out  1 each  verdict, exactly one high while res_valid.
REQ-018 SHALL have port res_neighbors  out  N  final neighbor count.
REQ-019 SHALL have port proto_err  out  1  sticky: hit_valid seen with zero outstanding.

Function
REQ-020 SHALL implement states IDLE, ISSUE, DRAIN, DONE; pt_ready=1 only in IDLE.
REQ-021 On acceptance SHALL latch size S, clear count/issued/received/outstanding; total batches T=ceil(S/LANES); next state ISSUE, or DONE if S=0.
REQ-022 In ISSUE, rd_en SHALL be high iff issued<T, outstanding<MAX_OUT, count<NEIGHBOR_TRESHOLD; rd_batch=issued; issued increments per rd_en.
REQ-023 Outstanding SHALL +1 on rd_en, -1 on accepted hit_valid, unchanged when both occur same cycle.
REQ-024 Responses SHALL be in issue order; response k's valid lanes are l with k*LANES+l<S; other lanes masked to 0.
REQ-025 On hit_valid in ISSUE, count SHALL add popcount of masked hit_mask, saturating at 2^N-1; registered next edge.
REQ-026 When registered count>=NEIGHBOR_TRESHOLD, SHALL stop issuing (rd_en low that cycle) and go to DRAIN; responses thereafter are discarded, count frozen.
REQ-027 DRAIN SHALL go to DONE in the cycle outstanding reaches 0; ISSUE SHALL go to DONE when received=T and count<threshold.
REQ-028 In DONE, res_valid=1, res_inlier=(count>=threshold), res_outlier=~res_inlier, res_neighbors=count; all held stable until res_ready; then IDLE next cycle.
REQ-029 hit_valid with outstanding=0 (incl. IDLE/DONE) SHALL be ignored and set proto_err.
REQ-030 rd_batch SHALL be truncated to ADDR_W; T>2^ADDR_W is out of scope.

Reset
REQ-031 With reset high at an edge, next cycle: state IDLE, pt_ready=1, rd_en=0, res_valid=0, res_inlier=0, res_outlier=0, res_neighbors=0, proto_err=0, all counters 0; reset overrides any in-flight operation.
REQ-032 Responses of aborted reads arriving after reset SHALL set proto_err.

Verification
REQ-033 S=0 accepted -> no rd_en; res_valid next cycle, outlier=1, neighbors=0.
REQ-034 S=100, all masks 0 -> exactly 4 rd_en, batches 0..3, never >4 outstanding; outlier=1, neighbors=0.
REQ-035 S=40, batch0 mask 0x0000000F, batch1 mask 0xFFFFFFFF -> only lanes 0-7 of batch1 counted; neighbors=12, outlier=1.
REQ-036 S=320, all masks 0xFFFFFFFF, responses 3 cycles after issue -> rd_en low after first response lands; DRAIN absorbs remaining; inlier=1, neighbors=32, proto_err=0.
REQ-037 res_ready low 5 cycles in DONE -> res_* stable, pt_ready=0; one cycle after handshake pt_ready=1.
REQ-038 reset pulse during ISSUE with 2 outstanding -> next cycle IDLE, all outputs reset; late hit_valid sets proto_err=1.
